// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//
// Two-stage pipelined ALU with a valid/ready handshake on both sides.
// It supports AND, OR, ADD, SUB, signed set-less-than and unsigned
// set-less-than.
//
//   S1 : registered operands and opcode, captured on in_valid && in_ready.
//   S2 : registered result, zero flag and illegal flag. S2 drives the
//        response port directly, with no combinational path from the inputs.
//
// At most two operations are buffered (one in S1, one in S2). A response
// stays stable while out_valid is high and out_ready is low. op_count is a
// wrapping count of the responses that the consumer has taken.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      request valid
//   in_ready   out  1      request can be accepted this cycle
//   A, B       in   WIDTH  operands
//   ALUCtrl    in   4      operation select
//   out_valid  out  1      response valid
//   out_ready  in   1      consumer takes the response this cycle
//   Y          out  WIDTH  result
//   ZERO       out  1      Y == 0
//   ILLEGAL    out  1      ALUCtrl was not a defined opcode
//   op_count   out  CNT_W  responses consumed, wraps
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUCtrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             ZERO,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000
  } alu_op_e;

  // Stage S1: captured request
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [3:0]       r_s1_ctrl;

  // Stage S2: computed response
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_y;
  logic             r_s2_zero;
  logic             r_s2_illegal;

  logic [CNT_W-1:0] r_op_count;

  // Handshake / advance control
  logic w_s2_free;
  logic w_s1_move;
  logic w_accept;
  logic w_drain;

  // ALU result computed from the S1 registers
  logic [WIDTH-1:0] w_y;
  logic             w_zero;
  logic             w_illegal;

  // S2 can take a new result when it is empty or is being drained this cycle.
  assign w_s2_free = !r_s2_valid || out_ready;
  assign w_s1_move = r_s1_valid && w_s2_free;
  // in_ready depends only on state and out_ready, never on in_valid, so the
  // initiator may wait for ready before it raises valid.
  assign in_ready  = !r_s1_valid || w_s1_move;
  assign w_accept  = in_valid && in_ready;
  assign w_drain   = r_s2_valid && out_ready;

  // ---------------------------------------------------------------------------
  // ALU function
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that does
    // not assign a variable would otherwise infer a latch.
    w_y       = '0;
    w_illegal = 1'b0;
    case (r_s1_ctrl)
      OP_AND:  w_y = r_s1_a & r_s1_b;
      OP_OR:   w_y = r_s1_a | r_s1_b;
      OP_ADD:  w_y = r_s1_a + r_s1_b;   // carry out is dropped
      OP_SUB:  w_y = r_s1_a - r_s1_b;   // borrow is dropped
      OP_SLT:  w_y = {{(WIDTH-1){1'b0}}, ($signed(r_s1_a) < $signed(r_s1_b))};
      OP_SLTU: w_y = {{(WIDTH-1){1'b0}}, (r_s1_a < r_s1_b)};
      default: w_illegal = 1'b1;        // Y stays 0, so ZERO reads 1
    endcase
    w_zero = (w_y == '0);
  end

  // ---------------------------------------------------------------------------
  // Stage S1
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge no matter how the statements are
    // ordered.
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
    end else if (w_s1_move) begin
      r_s1_valid <= 1'b0;
    end
  end

  // NOTE: the S1 payload has no reset. It is qualified by r_s1_valid, and
  // skipping the reset keeps these flops off the reset tree.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_a    <= A;
      r_s1_b    <= B;
      r_s1_ctrl <= ALUCtrl;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage S2. Its payload is visible on the ports, so it is reset to zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid   <= 1'b0;
      r_s2_y       <= '0;
      r_s2_zero    <= 1'b0;
      r_s2_illegal <= 1'b0;
    end else if (w_s1_move) begin
      r_s2_valid   <= 1'b1;
      r_s2_y       <= w_y;
      r_s2_zero    <= w_zero;
      r_s2_illegal <= w_illegal;
    end else if (w_drain) begin
      // Payload is held. Only the valid flag drops when nothing refills S2.
      r_s2_valid   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Completed-operation counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_drain) begin
      r_op_count <= r_op_count + 1'b1;  // wraps naturally at 2^CNT_W
    end
  end

  assign out_valid = r_s2_valid;
  assign Y         = r_s2_y;
  assign ZERO      = r_s2_zero;
  assign ILLEGAL   = r_s2_illegal;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
//
// Self-checking bench for alu_pipe. The reference model is a queue of
// expected responses. Each entry holds the expected value and the cycle in
// which its request was presented.
//
// The bench derives these expectations at the transaction level:
//   - out_valid must be high iff an op is pending and at least 2 cycles have
//     passed since it was presented.
//   - in_ready must be high iff fewer than 2 ops are pending or the consumer
//     drains this cycle.
//   - Responses come out in order with the ALU value.
//   - op_count equals the number of drained responses.
//
// A second instance with CNT_W=4 shares the stimulus and exercises the
// counter wrap.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready, in_ready4;
  logic [W-1:0]  a, b;
  logic [3:0]    ctrl;
  logic          out_valid, out_valid4;
  logic          out_ready;
  logic [W-1:0]  y, y4;
  logic          zero, zero4, ill, ill4;
  logic [CW-1:0] op_count;
  logic [3:0]    op_count4;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .ALUCtrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .Y(y), .ZERO(zero), .ILLEGAL(ill), .op_count(op_count)
  );

  alu_pipe #(.WIDTH(W), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .A(a), .B(b), .ALUCtrl(ctrl), .out_valid(out_valid4), .out_ready(out_ready),
    .Y(y4), .ZERO(zero4), .ILLEGAL(ill4), .op_count(op_count4)
  );

  typedef struct {
    logic [W-1:0] y;
    logic         z;
    logic         ill;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           now;
  int           compared;
  int           mismatched;
  int           model_cnt;
  int           accepts;
  int           drains;

  // Directed tests supply their own literal expectation for the next accept.
  logic         lit_en;
  logic [W-1:0] lit_y;
  logic         lit_z, lit_ill;

  logic         prev_stall;
  logic [W-1:0] prev_y;
  logic         prev_z, prev_ill;

  // Reference ALU written straight from the opcode table.
  function automatic exp_t ref_op(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                  input logic [3:0] fc);
    exp_t e;
    e.ill = 1'b0;
    case (fc)
      4'd0:    e.y = fa & fb;
      4'd1:    e.y = fa | fb;
      4'd2:    e.y = W'(fa + fb);
      4'd6:    e.y = W'(fa - fb);
      4'd7:    e.y = ($signed(fa) < $signed(fb)) ? W'(1) : W'(0);
      4'd8:    e.y = (fa < fb) ? W'(1) : W'(0);
      default: begin e.y = '0; e.ill = 1'b1; end
    endcase
    e.z   = (e.y == '0);
    e.cyc = 0;
    return e;
  endfunction

  function automatic logic [3:0] rand_ctrl();
    logic [3:0] legal [6];
    legal = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8};
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
    return legal[$urandom_range(0, 5)];
  endfunction

  // One clock cycle. Inputs are already driven (we are at a negedge). Outputs
  // are checked at negedge+1, then the handshakes are applied to the model.
  task automatic cycle();
    exp_t e;
    logic exp_ov, exp_rdy, acc, drn;
    #1;
    exp_ov  = (q.size() > 0) && (now >= q[0].cyc + 2);
    exp_rdy = (q.size() < 2) || out_ready;

    compared++;
    if (in_ready !== exp_rdy) begin
      mismatched++;
      $display("FAIL in_ready: got %b want %b (cycle %0d)", in_ready, exp_rdy, now);
    end
    compared++;
    if (out_valid !== exp_ov) begin
      mismatched++;
      $display("FAIL out_valid: got %b want %b (cycle %0d)", out_valid, exp_ov, now);
    end
    compared++;
    if (out_valid4 !== exp_ov || in_ready4 !== exp_rdy) begin
      mismatched++;
      $display("FAIL dut4_hs: got v=%b r=%b want v=%b r=%b (cycle %0d)",
               out_valid4, in_ready4, exp_ov, exp_rdy, now);
    end
    compared++;
    if (op_count !== CW'(model_cnt) || op_count4 !== 4'(model_cnt)) begin
      mismatched++;
      $display("FAIL op_count: got %0d/%0d want %0d/%0d (cycle %0d)",
               op_count, op_count4, CW'(model_cnt), 4'(model_cnt), now);
    end
    if (prev_stall) begin
      compared++;
      if (out_valid !== 1'b1 || y !== prev_y || zero !== prev_z || ill !== prev_ill) begin
        mismatched++;
        $display("FAIL hold: got v=%b y=%h z=%b i=%b want v=1 y=%h z=%b i=%b (cycle %0d)",
                 out_valid, y, zero, ill, prev_y, prev_z, prev_ill, now);
      end
    end

    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL spurious_resp: got y=%h want no response (cycle %0d)", y, now);
      end else begin
        e = q.pop_front();
        if (y !== e.y || zero !== e.z || ill !== e.ill || y4 !== e.y || zero4 !== e.z ||
            ill4 !== e.ill) begin
          mismatched++;
          $display("FAIL resp: got y=%h z=%b i=%b (y4=%h) want y=%h z=%b i=%b (cycle %0d)",
                   y, zero, ill, y4, e.y, e.z, e.ill, now);
        end
      end
      model_cnt++;
      drains++;
    end
    if (acc) begin
      if (lit_en) begin
        e.y = lit_y; e.z = lit_z; e.ill = lit_ill;
      end else begin
        e = ref_op(a, b, ctrl);
      end
      e.cyc = now;
      q.push_back(e);
      accepts++;
    end
    prev_stall = out_valid && !out_ready;
    prev_y = y; prev_z = zero; prev_ill = ill;
    @(posedge clk);
    @(negedge clk);
    now++;
  endtask

  task automatic rand_inputs();
    a    = $urandom();
    b    = $urandom();
    ctrl = rand_ctrl();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      cycle();
    end
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
    cycle();
    cycle();
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    rand_inputs();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      compared++;
      if (out_valid !== 1'b0 || y !== '0 || zero !== 1'b0 || ill !== 1'b0 ||
          op_count !== '0 || op_count4 !== '0) begin
        mismatched++;
        $display("FAIL reset_state: got v=%b y=%h z=%b i=%b cnt=%0d cnt4=%0d want all 0",
                 out_valid, y, zero, ill, op_count, op_count4);
      end
    end
    rst        = 1'b0;
    in_valid   = 1'b0;
    q.delete();
    model_cnt  = 0;
    prev_stall = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    now++;
  endtask

  task automatic test_reset();
    do_reset(2);
    cycle();
  endtask

  // Directed vectors with literal expectations, each sent alone so that the
  // 2-cycle latency is seen in isolation.
  task automatic test_ops();
    logic [W-1:0] va [10];
    logic [W-1:0] vb [10];
    logic [3:0]   vc [10];
    logic [W-1:0] vy [10];
    logic         vz [10];
    logic         vi [10];
    va = '{32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h5A5A_5A5A,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
    vb = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h5A5A_5A5A,
           32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0005};
    vc = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0110,
           4'b0111, 4'b1000, 4'b1111, 4'b0010, 4'b0110};
    vy = '{32'h0000_0000, 32'h1000_1000, 32'h1000_1000, 32'h0FFF_F000, 32'h0000_0000,
           32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFE};
    vz = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vi = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = va[i]; b = vb[i]; ctrl = vc[i];
      lit_en = 1'b1; lit_y = vy[i]; lit_z = vz[i]; lit_ill = vi[i];
      cycle();
      lit_en   = 1'b0;
      in_valid = 1'b0;
      rand_inputs();
      cycle();
      cycle();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int d0;
    do_reset(1);
    out_ready = 1'b1;
    d0 = drains;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      rand_inputs();
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();
    compared++;
    if (drains - d0 != 10 || op_count !== CW'(10)) begin
      mismatched++;
      $display("FAIL stream: got %0d responses cnt=%0d want 10 cnt=10", drains - d0, op_count);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int a0;
    out_ready = 1'b0;
    a0 = accepts;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      rand_inputs();
      cycle();
    end
    compared++;
    if (accepts - a0 != 2) begin
      mismatched++;
      $display("FAIL bp_accepts: got %0d want 2", accepts - a0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      rand_inputs();
      cycle();
    end
    compared++;
    if (accepts - a0 != 8) begin
      mismatched++;
      $display("FAIL bp_resume: got %0d accepts want 8", accepts - a0);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rand_inputs();
      cycle();
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    int d0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      rand_inputs();
      cycle();
    end
    compared++;
    if (q.size() != 2) begin
      mismatched++;
      $display("FAIL inflight: got %0d pending want 2", q.size());
    end
    do_reset(1);
    d0 = drains;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    compared++;
    if (drains != d0 || op_count !== '0) begin
      mismatched++;
      $display("FAIL flush: got %0d responses cnt=%0d want 0 cnt=0", drains - d0, op_count);
    end
  endtask

  task automatic test_wrap();
    do_reset(1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      rand_inputs();
      cycle();
    end
    drain();
    compared++;
    if (op_count4 !== 4'd0 || op_count !== CW'(16)) begin
      mismatched++;
      $display("FAIL wrap: got cnt4=%0d cnt=%0d want cnt4=0 cnt=16", op_count4, op_count);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    model_cnt  = 0;
    accepts    = 0;
    drains     = 0;
    now        = 0;
    lit_en     = 1'b0;
    lit_y      = '0;
    lit_z      = 1'b0;
    lit_ill    = 1'b0;
    prev_stall = 1'b0;
    prev_y     = '0;
    prev_z     = 1'b0;
    prev_ill   = 1'b0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;
    ctrl       = '0;
    @(negedge clk);
    test_reset();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
